// File: rtl/mux_arb_pkg.sv
// Shared types, sizes and the round-robin winner function for the
// 4-source multiplexer arbiter.
package mux_arb_pkg;

  localparam int N_SRC = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arbState_t;

  // First asserted request scanning upward from last+1, wrapping modulo 4.
  // The previous owner is therefore considered last.
  function automatic logic [SEL_W-1:0] rrWinner(input logic [N_SRC-1:0] req,
                                                input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] win;
    logic             found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/multiplexer.sv
// 4:1 data multiplexer shared between the arbitrated sources.
module multiplexer #(
  parameter int W = 2
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] C,
  input  logic [W-1:0] D,
  input  logic [1:0]   SEL,
  output logic [W-1:0] X
);

  always_comb begin
    X = A;
    case (SEL)
      2'b00: X = A;
      2'b01: X = B;
      2'b10: X = C;
      2'b11: X = D;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the multiplexer select; grants one source at a
// time for at most HOLD_CYCLES cycles and presents its data on X with VALID.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int W           = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_SRC-1:0] REQ,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [W-1:0]     C,
  input  logic [W-1:0]     D,
  output logic [N_SRC-1:0] GNT,
  output logic [SEL_W-1:0] SEL,
  output logic [W-1:0]     X,
  output logic             VALID
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  arbState_t        state, nextState;
  logic [3:0]       cnt, nextCnt;
  logic [SEL_W-1:0] sel, nextSel;
  logic [SEL_W-1:0] last, nextLast;
  logic [N_SRC-1:0] gnt, nextGnt;
  logic [SEL_W-1:0] winner;
  logic             grantEnd;
  logic [W-1:0]     muxOut;

  // LAST resets to 3 so that source A is first in line after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sel   <= '0;
      last  <= 2'b11;
      gnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      sel   <= nextSel;
      last  <= nextLast;
      gnt   <= nextGnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    nextSel   = sel;
    nextLast  = last;
    nextGnt   = gnt;
    winner    = rrWinner(REQ, last);
    grantEnd  = (cnt == 4'd0) || !REQ[sel];
    case (state)
      ST_IDLE: begin
        if (|REQ) begin
          nextState = ST_GRANT;
          nextSel   = winner;
          nextLast  = winner;
          nextGnt   = 4'b0001 << winner;
          nextCnt   = HOLD_LOAD;
        end
      end
      ST_GRANT: begin
        // Timeout and owner release collapse into one grant end; any pending
        // request is served at the same edge without an idle bubble.
        if (grantEnd) begin
          if (|REQ) begin
            nextSel  = winner;
            nextLast = winner;
            nextGnt  = 4'b0001 << winner;
            nextCnt  = HOLD_LOAD;
          end else begin
            nextState = ST_IDLE;
            nextGnt   = '0;
            nextCnt   = '0;
          end
        end else begin
          nextCnt = cnt - 4'd1;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    GNT   = gnt;
    SEL   = sel;
    VALID = (state == ST_GRANT);
    X     = VALID ? muxOut : '0;
  end

  multiplexer #(.W(W)) uMux (
    .A  (A),
    .B  (B),
    .C  (C),
    .D  (D),
    .SEL(sel),
    .X  (muxOut)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed, table-driven bench for mux_rr_arbiter with HOLD_CYCLES=4 and a
// second instance with HOLD_CYCLES=1 for per-cycle rotation.
module tb_mux_rr_arbiter;

  typedef struct {
    string      name;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [1:0] x;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [3:0] REQ = 4'b0000;
  logic [1:0] A = 2'b11;
  logic [1:0] B = 2'b10;
  logic [1:0] C = 2'b01;
  logic [1:0] D = 2'b00;

  logic [3:0] gnt4, gnt1;
  logic [1:0] sel4, sel1;
  logic [1:0] x4, x1;
  logic       valid4, valid1;

  int passCount = 0;
  int checkCount = 0;
  vec_t vecs[$];

  always #5 CLK = ~CLK;

  mux_rr_arbiter #(.HOLD_CYCLES(4), .W(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
    .A(A), .B(B), .C(C), .D(D),
    .GNT(gnt4), .SEL(sel4), .X(x4), .VALID(valid4)
  );

  mux_rr_arbiter #(.HOLD_CYCLES(1), .W(2)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
    .A(A), .B(B), .C(C), .D(D),
    .GNT(gnt1), .SEL(sel1), .X(x1), .VALID(valid1)
  );

  task automatic addVec(input string name, input logic [3:0] req, input logic [3:0] gnt,
                        input logic [1:0] sel, input logic valid, input logic [1:0] x,
                        input int count);
    vec_t v;
    for (int i = 0; i < count; i++) begin
      v.name  = name;
      v.req   = req;
      v.gnt   = gnt;
      v.sel   = sel;
      v.valid = valid;
      v.x     = x;
      vecs.push_back(v);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req);
    REQ = req;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name,
                             input logic [3:0] actG, input logic [1:0] actS,
                             input logic actV, input logic [1:0] actX,
                             input logic [3:0] expG, input logic [1:0] expS,
                             input logic expV, input logic [1:0] expX);
    checkCount++;
    if (actG === expG && actS === expS && actV === expV && actX === expX) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got gnt=%b sel=%b valid=%b x=%b, expected gnt=%b sel=%b valid=%b x=%b",
               name, actG, actS, actV, actX, expG, expS, expV, expX);
    end
  endtask

  initial begin
    logic [3:0] rotGnt [5];
    logic [1:0] rotSel [5];
    logic [1:0] rotX   [5];
    rotGnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rotSel = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    rotX   = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11};

    // All sources requesting: A, B, C, D, A, four cycles each.
    addVec("rot_A",   4'b1111, 4'b0001, 2'b00, 1'b1, 2'b11, 4);
    addVec("rot_B",   4'b1111, 4'b0010, 2'b01, 1'b1, 2'b10, 4);
    addVec("rot_C",   4'b1111, 4'b0100, 2'b10, 1'b1, 2'b01, 4);
    addVec("rot_D",   4'b1111, 4'b1000, 2'b11, 1'b1, 2'b00, 4);
    addVec("rot_A2",  4'b1111, 4'b0001, 2'b00, 1'b1, 2'b11, 1);
    addVec("idle1",   4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00, 1);
    // Lone requester C is re-granted across the hold boundary without a bubble.
    addVec("single_C", 4'b0100, 4'b0100, 2'b10, 1'b1, 2'b01, 9);
    addVec("idle2",   4'b0000, 4'b0000, 2'b10, 1'b0, 2'b00, 1);
    // B released on its second grant cycle; D takes over at the next edge.
    addVec("early_B1", 4'b0010, 4'b0010, 2'b01, 1'b1, 2'b10, 1);
    addVec("early_B2", 4'b1010, 4'b0010, 2'b01, 1'b1, 2'b10, 1);
    addVec("early_D",  4'b1000, 4'b1000, 2'b11, 1'b1, 2'b00, 1);
    addVec("idle3",   4'b0000, 4'b0000, 2'b11, 1'b0, 2'b00, 1);

    REQ = 4'b1111;
    #2 RST_N = 1'b0;
    #1 checkOutput("reset_async", gnt4, sel4, valid4, x4, 4'b0000, 2'b00, 1'b0, 2'b00);
    repeat (2) @(posedge CLK);
    #1 checkOutput("reset_hold", gnt4, sel4, valid4, x4, 4'b0000, 2'b00, 1'b0, 2'b00);
    RST_N = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req);
      checkOutput(vecs[i].name, gnt4, sel4, valid4, x4,
                  vecs[i].gnt, vecs[i].sel, vecs[i].valid, vecs[i].x);
    end

    // Reset pulsed during C's grant; arbitration restarts at A.
    applyStimulus(4'b0100);
    checkOutput("midrst_C", gnt4, sel4, valid4, x4, 4'b0100, 2'b10, 1'b1, 2'b01);
    #2 RST_N = 1'b0;
    #1 checkOutput("midrst_async", gnt4, sel4, valid4, x4, 4'b0000, 2'b00, 1'b0, 2'b00);
    @(posedge CLK);
    #1 checkOutput("midrst_hold", gnt4, sel4, valid4, x4, 4'b0000, 2'b00, 1'b0, 2'b00);
    RST_N = 1'b1;
    applyStimulus(4'b1111);
    checkOutput("midrst_A", gnt4, sel4, valid4, x4, 4'b0001, 2'b00, 1'b1, 2'b11);

    // HOLD_CYCLES=1 instance, reset alongside, rotates every cycle.
    checkOutput("h1_rot0", gnt1, sel1, valid1, x1, rotGnt[0], rotSel[0], 1'b1, rotX[0]);
    for (int k = 1; k < 5; k++) begin
      applyStimulus(4'b1111);
      checkOutput($sformatf("h1_rot%0d", k), gnt1, sel1, valid1, x1,
                  rotGnt[k], rotSel[k], 1'b1, rotX[k]);
    end
    applyStimulus(4'b0000);
    checkOutput("h1_idle", gnt1, sel1, valid1, x1, 4'b0000, 2'b00, 1'b0, 2'b00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
